// File: rtl/fixed_point_pkg.sv
// Shared types and constants for the FixedPointArithmetic serial units.
package fixed_point_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} serial_state_t;

  localparam string MODEL_BEHAVIORAL = "Behavioral";
  localparam string MODEL_DATAFLOW   = "DataFlow";
  localparam string MODEL_STRUCTURAL = "Structural";

endpackage

// File: rtl/serial_subtract_if.sv
// Valid/ready operand and result channels of the serial subtractor.
interface serial_subtract_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bi;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             bo;
  logic             ovf;

  modport master (
    output in_valid, a, b, bi, out_ready,
    input  in_ready, out_valid, d, bo, ovf
  );

  modport slave (
    input  in_valid, a, b, bi, out_ready,
    output in_ready, out_valid, d, bo, ovf
  );
endinterface

// File: rtl/serial_subtract_full_subtract_bit.sv
// Combinational 1-bit full subtractor (d = a - b - bi), cell style chosen by MODEL.
module full_subtract_bit
  import fixed_point_pkg::*;
#(
  parameter string MODEL = MODEL_BEHAVIORAL
) (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  if (MODEL == MODEL_STRUCTURAL) begin : g_structural
    // Two cascaded half subtractors; borrow out is the OR of their borrows.
    logic w_d1, w_b1, w_b2;
    assign w_d1 = a ^ b;
    assign w_b1 = ~a & b;
    assign w_b2 = ~w_d1 & bi;
    assign d    = w_d1 ^ bi;
    assign bo   = w_b1 | w_b2;
  end else if (MODEL == MODEL_DATAFLOW) begin : g_dataflow
    assign d  = a ^ b ^ bi;
    assign bo = (~a & b) | (~(a ^ b) & bi);
  end else begin : g_behavioral
    always_comb begin
      d  = 1'b0;
      bo = 1'b0;
      case ({a, b, bi})
        3'b000: begin d = 1'b0; bo = 1'b0; end
        3'b001: begin d = 1'b1; bo = 1'b1; end
        3'b010: begin d = 1'b1; bo = 1'b1; end
        3'b011: begin d = 1'b0; bo = 1'b1; end
        3'b100: begin d = 1'b1; bo = 1'b0; end
        3'b101: begin d = 1'b0; bo = 1'b0; end
        3'b110: begin d = 1'b0; bo = 1'b0; end
        default: begin d = 1'b1; bo = 1'b1; end
      endcase
    end
  end

endmodule

// File: rtl/serial_subtract.sv
// Bit-serial LSB-first two's-complement subtractor: d = a - b - bi over WIDTH cycles.
module serial_subtract
  import fixed_point_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter string       MODEL = MODEL_BEHAVIORAL
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  serial_subtract_if.slave bus
);

  localparam int unsigned    CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  serial_state_t    r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a, r_b, r_d;
  logic             r_br, r_bo, r_ovf;
  logic             w_load, w_in_ready, w_out_valid;
  logic             w_d, w_bo;

  full_subtract_bit #(.MODEL(MODEL)) u_cell (
    .a  (r_a[0]),
    .b  (r_b[0]),
    .bi (r_br),
    .d  (w_d),
    .bo (w_bo)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_load      = 1'b0;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_load = 1'b1;
          w_next = SHIFT;
        end
      end
      SHIFT: begin
        if (r_cnt == LAST) w_next = DONE;
      end
      DONE: begin
        w_out_valid = 1'b1;
        // Retiring the result frees the datapath, so a waiting operand set loads in the same cycle.
        w_in_ready  = bus.out_ready;
        if (bus.out_ready) begin
          w_load = bus.in_valid;
          w_next = bus.in_valid ? SHIFT : IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_d   <= '0;
      r_br  <= 1'b0;
      r_bo  <= 1'b0;
      r_ovf <= 1'b0;
    end else if (w_load) begin
      r_a   <= bus.a;
      r_b   <= bus.b;
      r_br  <= bus.bi;
      r_cnt <= '0;
    end else if (r_state == SHIFT) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_d   <= {w_d, r_d[WIDTH-1:1]};
      r_br  <= w_bo;
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == LAST) begin
        // r_br here is the borrow into the MSB.
        r_bo  <= w_bo;
        r_ovf <= r_br ^ w_bo;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.d         = r_d;
  assign bus.bo        = r_bo;
  assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_serial_subtract.sv
// Bench for serial_subtract: all three cell models driven in lockstep, checked against an arithmetic model.
module tb_serial_subtract;
  import fixed_point_pkg::*;

  localparam int unsigned W = 8;

  logic clk, rst_n;
  int   checks, errors;

  serial_subtract_if #(.WIDTH(W)) bus_b ();
  serial_subtract_if #(.WIDTH(W)) bus_f ();
  serial_subtract_if #(.WIDTH(W)) bus_s ();

  assign bus_f.in_valid  = bus_b.in_valid;
  assign bus_f.a         = bus_b.a;
  assign bus_f.b         = bus_b.b;
  assign bus_f.bi        = bus_b.bi;
  assign bus_f.out_ready = bus_b.out_ready;
  assign bus_s.in_valid  = bus_b.in_valid;
  assign bus_s.a         = bus_b.a;
  assign bus_s.b         = bus_b.b;
  assign bus_s.bi        = bus_b.bi;
  assign bus_s.out_ready = bus_b.out_ready;

  serial_subtract #(.WIDTH(W), .MODEL(MODEL_BEHAVIORAL)) u_beh (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus_b.slave));
  serial_subtract #(.WIDTH(W), .MODEL(MODEL_DATAFLOW)) u_df (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus_f.slave));
  serial_subtract #(.WIDTH(W), .MODEL(MODEL_STRUCTURAL)) u_st (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus_s.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bi;
    logic [7:0] ed;
    logic       ebo;
    logic       eovf;
  } vec_t;

  // Reference: unsigned difference gives d and borrow, signed difference gives overflow.
  function automatic logic [9:0] ref_sub(input logic [7:0] a, input logic [7:0] b, input logic bi);
    int u, s;
    logic [7:0] dd;
    u  = int'(a) - int'(b) - int'(bi);
    s  = int'($signed(a)) - int'($signed(b)) - int'(bi);
    dd = 8'(u);
    return {(s > 127) || (s < -128), u < 0, dd};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic get(input int m, output string mn, output logic [7:0] d, output logic bo,
                     output logic ovf, output logic ov, output logic ir);
    case (m)
      0: begin mn = "beh"; d = bus_b.d; bo = bus_b.bo; ovf = bus_b.ovf; ov = bus_b.out_valid; ir = bus_b.in_ready; end
      1: begin mn = "df";  d = bus_f.d; bo = bus_f.bo; ovf = bus_f.ovf; ov = bus_f.out_valid; ir = bus_f.in_ready; end
      default: begin mn = "st"; d = bus_s.d; bo = bus_s.bo; ovf = bus_s.ovf; ov = bus_s.out_valid; ir = bus_s.in_ready; end
    endcase
  endtask

  task automatic chk_res(input string tag, input logic [7:0] ed, input logic ebo, input logic eovf);
    string mn; logic [7:0] d; logic bo, ovf, ov, ir;
    for (int m = 0; m < 3; m++) begin
      get(m, mn, d, bo, ovf, ov, ir);
      chk($sformatf("%s/%s d", tag, mn), 32'(d), 32'(ed));
      chk($sformatf("%s/%s bo", tag, mn), 32'(bo), 32'(ebo));
      chk($sformatf("%s/%s ovf", tag, mn), 32'(ovf), 32'(eovf));
    end
  endtask

  task automatic chk_ctl(input string tag, input logic eov, input logic eir);
    string mn; logic [7:0] d; logic bo, ovf, ov, ir;
    for (int m = 0; m < 3; m++) begin
      get(m, mn, d, bo, ovf, ov, ir);
      chk($sformatf("%s/%s out_valid", tag, mn), 32'(ov), 32'(eov));
      chk($sformatf("%s/%s in_ready", tag, mn), 32'(ir), 32'(eir));
    end
  endtask

  // Present operands at a falling edge; returns one falling edge after the accepting rising edge.
  task automatic start(input logic [7:0] a, input logic [7:0] b, input logic bi);
    bus_b.in_valid = 1'b1;
    bus_b.a        = a;
    bus_b.b        = b;
    bus_b.bi       = bi;
    @(negedge clk);
    bus_b.in_valid = 1'b0;
    bus_b.a        = 8'($urandom);
    bus_b.b        = 8'($urandom);
    bus_b.bi       = 1'($urandom);
  endtask

  // Counts falling edges since the accept until out_valid; in_valid toggles with junk meanwhile.
  task automatic wait_result(output int lat);
    lat = 1;
    while (!bus_b.out_valid && lat < 40) begin
      bus_b.in_valid = 1'($urandom);
      bus_b.a        = 8'($urandom);
      bus_b.b        = 8'($urandom);
      @(negedge clk);
      lat++;
    end
    bus_b.in_valid = 1'b0;
  endtask

  task automatic retire(input string tag);
    bus_b.out_ready = 1'b1;
    @(negedge clk);
    bus_b.out_ready = 1'b0;
    #1;
    chk_ctl({tag, " retired"}, 1'b0, 1'b1);
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic bi, input int hold);
    logic [9:0] r;
    int lat;
    r = ref_sub(a, b, bi);
    start(a, b, bi);
    wait_result(lat);
    chk({tag, " latency"}, 32'(lat), 32'd9);
    chk_ctl({tag, " done"}, 1'b1, 1'b0);
    chk_res(tag, r[7:0], r[8], r[9]);
    repeat (hold) @(negedge clk);
    if (hold > 0) chk_res({tag, " held"}, r[7:0], r[8], r[9]);
    retire(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    vec_t v;
    logic [9:0] r;
    int lat;

    checks = 0;
    errors = 0;
    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[3] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[4] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[5] = '{8'hFF, 8'h7F, 1'b1, 8'h7F, 1'b0, 1'b1};

    rst_n           = 1'b0;
    bus_b.in_valid  = 1'b0;
    bus_b.out_ready = 1'b0;
    bus_b.a         = '0;
    bus_b.b         = '0;
    bus_b.bi        = 1'b0;
    repeat (2) @(negedge clk);
    chk_ctl("reset", 1'b0, 1'b1);
    chk_res("reset", 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_ctl("idle", 1'b0, 1'b1);

    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      start(v.a, v.b, v.bi);
      wait_result(lat);
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'd9);
      chk_res($sformatf("vec%0d", i), v.ed, v.ebo, v.eovf);
      retire($sformatf("vec%0d", i));
    end

    // Backpressure for 5 cycles, then back-to-back accept on the retiring cycle.
    r = ref_sub(8'h40, 8'h41, 1'b0);
    start(8'h40, 8'h41, 1'b0);
    wait_result(lat);
    for (int i = 0; i < 5; i++) begin
      chk_ctl($sformatf("bp%0d", i), 1'b1, 1'b0);
      chk_res($sformatf("bp%0d", i), r[7:0], r[8], r[9]);
      @(negedge clk);
    end
    bus_b.out_ready = 1'b1;
    bus_b.in_valid  = 1'b1;
    bus_b.a         = 8'h10;
    bus_b.b         = 8'h01;
    bus_b.bi        = 1'b0;
    #1;
    chk_ctl("b2b handshake", 1'b1, 1'b1);
    @(negedge clk);
    bus_b.out_ready = 1'b0;
    bus_b.in_valid  = 1'b0;
    chk_ctl("b2b shifting", 1'b0, 1'b0);
    wait_result(lat);
    chk("b2b latency", 32'(lat), 32'd9);
    chk_res("b2b", 8'h0F, 1'b0, 1'b0);
    retire("b2b");

    // Reset at cnt=4 discards the operation.
    start(8'h33, 8'h01, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_ctl("rst shift", 1'b0, 1'b1);
    chk_res("rst shift", 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("post rst", 8'h22, 8'h11, 1'b0, 0);

    // Reset while a result is pending drops out_valid at once.
    start(8'h80, 8'h01, 1'b0);
    wait_result(lat);
    chk_ctl("pre rst done", 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_ctl("rst done", 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 30; i++) begin
      run_op($sformatf("rnd%0d", i), 8'($urandom), 8'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
